// File: rtl/n_bit_multiplier_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
// Holds the controller state encoding and the BCD digit-count rule.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Decimal digits needed to cover a 2N-bit unsigned value.
  function automatic int bcd_digits(input int n);
    return (2 * n) / 3 + 1;
  endfunction

endpackage

// File: rtl/n_bit_multiplier_if.sv
// Operand/result bundle between a controller (master) and the multiplier (slave).
interface n_bit_multiplier_if #(
  parameter int N = 5
);
  import multiplier_pkg::*;

  localparam int D = bcd_digits(N);

  logic [N-1:0]     a_in;
  logic [N-1:0]     b_in;
  logic             start;
  logic [2*N-1:0]   out;
  logic             finish;
  logic [4*D-1:0]   bcd;

  modport master (
    output a_in, b_in, start,
    input  out, finish, bcd
  );

  modport slave (
    input  a_in, b_in, start,
    output out, finish, bcd
  );

endinterface

// File: rtl/n_bit_multiplier_bin2bcd.sv
// Combinational double-dabble binary-to-packed-BCD converter.
// Only built when MULTIPLIER_BCD_EN is defined; otherwise the file is empty.
`ifdef MULTIPLIER_BCD_EN
module bin2bcd #(
  parameter int W = 10,
  parameter int D = W / 3 + 1
) (
  input  logic [W-1:0]   bin,
  output logic [4*D-1:0] bcd
);

  logic [W+4*D-1:0] sr;

  always_comb begin
    sr          = '0;
    sr[W-1:0]   = bin;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < D; j++) begin
        if (sr[W+4*j +: 4] > 4'd4)
          sr[W+4*j +: 4] = sr[W+4*j +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
    bcd = sr[W+4*D-1:W];
  end

endmodule
`endif

// File: rtl/n_bit_multiplier.sv
// Sequential unsigned NxN shift-and-add multiplier with start/finish handshake.
// Optional packed-BCD copy of the product is built under MULTIPLIER_BCD_EN.
//
// state | meaning
// IDLE  | waiting for start; operands latched when it is seen
// BUSY  | one add/shift step per cycle, N steps total
// DONE  | product presented with finish=1 until start drops
module n_bit_multiplier
  import multiplier_pkg::*;
#(
  parameter int N = 5
) (
  input  logic               clk_sys,
  input  logic               rst_b,
  n_bit_multiplier_if.slave  bus
);

  localparam int D  = bcd_digits(N);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [2*N-1:0]   mcand;
  logic [N-1:0]     mplier;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   acc_step;
  logic [2*N-1:0]   prod;
  logic [CW-1:0]    step;
  logic             fin;
  logic             last_step;

  assign acc_step  = acc + (mplier[0] ? mcand : '0);
  assign last_step = (step == LAST_STEP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (!bus.start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      step   <= '0;
      prod   <= '0;
      fin    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{N{1'b0}}, bus.a_in};
            mplier <= bus.b_in;
            acc    <= '0;
            step   <= '0;
          end
        end
        BUSY: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step   <= step + 1'b1;
          // prod only moves here, so it holds the last result through IDLE/BUSY
          if (last_step) begin
            prod <= acc_step;
            fin  <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.start) fin <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.out    = prod;
  assign bus.finish = fin;

`ifdef MULTIPLIER_BCD_EN
  bin2bcd #(
    .W (2 * N),
    .D (D)
  ) u_bin2bcd (
    .bin (prod),
    .bcd (bus.bcd)
  );
`else
  assign bus.bcd = '0;
`endif

endmodule

// File: tb/tb_n_bit_multiplier.sv
// Self-checking bench for n_bit_multiplier: directed cases, boundaries,
// mid-operation reset, operand scrambling and randomized back-to-back products.
module tb_n_bit_multiplier;
  import multiplier_pkg::*;

  localparam int N = 5;
  localparam int W = 2 * N;
  localparam int D = bcd_digits(N);

  logic clk_sys;
  logic rst_b;
  int   checks;
  int   errors;

  n_bit_multiplier_if #(.N(N)) bus ();

  n_bit_multiplier #(.N(N)) dut (
    .clk_sys (clk_sys),
    .rst_b   (rst_b),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Decimal digits of v, least-significant digit in [3:0]; all zeros when BCD is not built.
  function automatic logic [4*D-1:0] ref_bcd(input int v);
    logic [4*D-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifndef MULTIPLIER_BCD_EN
    r = '0;
`endif
    return r;
  endfunction

  // Present operands with start=1 and count edges until finish; lat=-1 on timeout.
  task automatic run_product(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
    @(posedge clk_sys); #1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    lat = -1;
    for (int e = 1; e <= 4 * N; e++) begin
      @(posedge clk_sys); #1;
      if (bus.finish) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic release_start();
    bus.start = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic test_reset();
    rst_b     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++; if (bus.out !== '0) begin errors++; $display("FAIL reset_out: got %0d want 0", bus.out); end
    checks++; if (bus.finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b want 0", bus.finish); end
    checks++; if (bus.bcd !== '0) begin errors++; $display("FAIL reset_bcd: got %h want 0", bus.bcd); end
    rst_b = 1'b1;
  endtask

  task automatic test_directed();
    int lat;
    logic [4*D-1:0] lit_bcd;
`ifdef MULTIPLIER_BCD_EN
    lit_bcd = 16'h0780;
`else
    lit_bcd = '0;
`endif
    run_product(5'd26, 5'd30, lat);
    checks++; if (lat != N + 1) begin errors++; $display("FAIL dir_latency: got %0d want %0d", lat, N + 1); end
    checks++; if (bus.out !== W'(780)) begin errors++; $display("FAIL dir_out: got %0d want 780", bus.out); end
    checks++; if (bus.bcd !== lit_bcd) begin errors++; $display("FAIL dir_bcd: got %h want %h", bus.bcd, lit_bcd); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_sys); #1;
      checks++;
      if (bus.finish !== 1'b1 || bus.out !== W'(780)) begin
        errors++; $display("FAIL dir_hold: finish=%b out=%0d want finish=1 out=780", bus.finish, bus.out);
      end
    end
    release_start();
    checks++; if (bus.finish !== 1'b0) begin errors++; $display("FAIL dir_drop_finish: got %b want 0", bus.finish); end
    checks++; if (bus.out !== W'(780)) begin errors++; $display("FAIL dir_drop_out: got %0d want 780", bus.out); end
    run_product(5'd13, 5'd13, lat);
    checks++; if (lat != N + 1) begin errors++; $display("FAIL dir2_latency: got %0d want %0d", lat, N + 1); end
    checks++; if (bus.out !== W'(169)) begin errors++; $display("FAIL dir2_out: got %0d want 169", bus.out); end
    checks++; if (bus.bcd !== ref_bcd(169)) begin errors++; $display("FAIL dir2_bcd: got %h want %h", bus.bcd, ref_bcd(169)); end
    release_start();
  endtask

  task automatic test_boundaries();
    int ta [3] = '{31, 0, 1};
    int tb [3] = '{31, 31, 1};
    int lat;
    int p;
    for (int k = 0; k < 3; k++) begin
      p = ta[k] * tb[k];
      run_product(N'(ta[k]), N'(tb[k]), lat);
      checks++; if (lat != N + 1) begin errors++; $display("FAIL bnd_latency %0dx%0d: got %0d want %0d", ta[k], tb[k], lat, N + 1); end
      checks++; if (bus.out !== W'(p)) begin errors++; $display("FAIL bnd_out %0dx%0d: got %0d want %0d", ta[k], tb[k], bus.out, p); end
      checks++; if (bus.bcd !== ref_bcd(p)) begin errors++; $display("FAIL bnd_bcd %0dx%0d: got %h want %h", ta[k], tb[k], bus.bcd, ref_bcd(p)); end
      release_start();
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    @(posedge clk_sys); #1;
    bus.a_in  = 5'd21;
    bus.b_in  = 5'd17;
    bus.start = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
    rst_b     = 1'b0;
    bus.start = 1'b0;
    @(posedge clk_sys); #1;
    checks++; if (bus.out !== '0) begin errors++; $display("FAIL midrst_out: got %0d want 0", bus.out); end
    checks++; if (bus.finish !== 1'b0) begin errors++; $display("FAIL midrst_finish: got %b want 0", bus.finish); end
    checks++; if (bus.bcd !== '0) begin errors++; $display("FAIL midrst_bcd: got %h want 0", bus.bcd); end
    rst_b = 1'b1;
    run_product(5'd7, 5'd9, lat);
    checks++; if (lat != N + 1) begin errors++; $display("FAIL postrst_latency: got %0d want %0d", lat, N + 1); end
    checks++; if (bus.out !== W'(63)) begin errors++; $display("FAIL postrst_out: got %0d want 63", bus.out); end
    release_start();
  endtask

  task automatic test_operand_change();
    int lat;
    @(posedge clk_sys); #1;
    bus.a_in  = 5'd19;
    bus.b_in  = 5'd22;
    bus.start = 1'b1;
    lat = -1;
    for (int e = 1; e <= 4 * N; e++) begin
      @(posedge clk_sys); #1;
      bus.a_in = N'($urandom);
      bus.b_in = N'($urandom);
      if (bus.finish) begin lat = e; break; end
    end
    checks++; if (lat != N + 1) begin errors++; $display("FAIL opchg_latency: got %0d want %0d", lat, N + 1); end
    checks++; if (bus.out !== W'(418)) begin errors++; $display("FAIL opchg_out: got %0d want 418", bus.out); end
    release_start();
  endtask

  task automatic test_back_to_back();
    int a, b, p, lat, prev, drop;
    prev = int'(bus.out);
    for (int it = 0; it < 24; it++) begin
      a    = int'($urandom_range(0, 31));
      b    = int'($urandom_range(0, 31));
      p    = a * b;
      drop = int'($urandom_range(0, 2) == 0);
      @(posedge clk_sys); #1;
      bus.a_in  = N'(a);
      bus.b_in  = N'(b);
      bus.start = 1'b1;
      lat = -1;
      for (int e = 1; e <= 4 * N; e++) begin
        @(posedge clk_sys); #1;
        if (bus.finish) begin lat = e; break; end
        checks++;
        if (bus.out !== W'(prev)) begin errors++; $display("FAIL rnd_out_held it%0d: got %0d want %0d", it, bus.out, prev); end
        if (drop != 0 && e == 2) bus.start = 1'b0;
        if ((e % 2) == 1) begin bus.a_in = N'($urandom); bus.b_in = N'($urandom); end
      end
      checks++; if (lat != N + 1) begin errors++; $display("FAIL rnd_latency it%0d: got %0d want %0d", it, lat, N + 1); end
      checks++; if (bus.out !== W'(p)) begin errors++; $display("FAIL rnd_out it%0d %0dx%0d: got %0d want %0d", it, a, b, bus.out, p); end
      checks++; if (bus.bcd !== ref_bcd(p)) begin errors++; $display("FAIL rnd_bcd it%0d: got %h want %h", it, bus.bcd, ref_bcd(p)); end
      release_start();
      checks++; if (bus.finish !== 1'b0) begin errors++; $display("FAIL rnd_finish_clear it%0d: got %b want 0", it, bus.finish); end
      prev = p;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_b     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    test_reset();
    test_directed();
    test_boundaries();
    test_reset_mid_busy();
    test_operand_change();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
